screen_driver: RTL and testbench

SCREEN_DRIVER -- requirements
Module: screen_driver

---
 rtl/screen_driver.sv | 176 +++++++++++++++++
 tb/tb_screen_driver.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/screen_driver.sv
// ---------------------------------------------------------------------------
// screen_driver
//
// Brings up an SSD1306 128x64 OLED over a write-only SPI link and then
// streams the frame buffer to it forever.
//
// Power-up: hold the display reset high, pulse it low, wait again. Each phase
// lasts STARTUP_WAIT cycles. Then the 20-byte init ROM is sent as command
// bytes. After that, data bytes are fetched from the upstream text engine one
// address at a time and shifted out, MSB first.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   resetN       asynchronous active-low reset
//   ioSclk       SPI clock, idle high, display samples on its rising edge
//   ioSdin       SPI data, MSB first, 0 whenever no byte is being shifted
//   ioCs         chip select, active-low, low only while a byte is shifted
//   ioDc         0 = command byte, 1 = display data byte
//   ioReset      display reset, active-low
//   pixelAddress byte index 0..1023 into the frame, to the text engine
//   pixelData    frame byte for pixelAddress, valid one clk after the address
//
// Build option
//   SCREEN_INVERT_EN  when defined, every data byte is inverted before it is
//                     shifted. Command bytes are never inverted.
// ---------------------------------------------------------------------------
module screen_driver #(
  parameter logic [31:0] STARTUP_WAIT = 32'd10000000
) (
  input  logic       clk,
  input  logic       resetN,
  output logic       ioSclk,
  output logic       ioSdin,
  output logic       ioCs,
  output logic       ioDc,
  output logic       ioReset,
  output logic [9:0] pixelAddress,
  input  logic [7:0] pixelData
);

  localparam logic [2:0] WAIT_HIGH   = 3'd0;
  localparam logic [2:0] RESET_PULSE = 3'd1;
  localparam logic [2:0] WAIT_POST   = 3'd2;
  localparam logic [2:0] LOAD_CMD    = 3'd3;
  localparam logic [2:0] SEND        = 3'd4;
  localparam logic [2:0] CHECK_INIT  = 3'd5;
  localparam logic [2:0] LOAD_DATA   = 3'd6;
  localparam logic [2:0] FETCH_DATA  = 3'd7;

  localparam logic [4:0]  LAST_CMD  = 5'd19;
  localparam logic [31:0] WAIT_LAST = STARTUP_WAIT - 32'd1;

  logic [2:0]  state;
  logic [31:0] waitCount;
  logic [4:0]  cmdIndex;
  logic [7:0]  shiftReg;
  logic [2:0]  bitCount;
  logic        phase;
  logic [7:0]  romByte;
  logic [7:0]  dataByte;

  // Init sequence: display off, contrast, normal display, horizontal
  // addressing, scan direction, start line, segment remap, multiplex,
  // clock divide, precharge, VCOMH, charge pump on, display on.
  always_comb begin
    romByte = 8'h00;
    case (cmdIndex)
      5'd0:  romByte = 8'hAE;
      5'd1:  romByte = 8'h81;
      5'd2:  romByte = 8'h7F;
      5'd3:  romByte = 8'hA6;
      5'd4:  romByte = 8'h20;
      5'd5:  romByte = 8'h00;
      5'd6:  romByte = 8'hC8;
      5'd7:  romByte = 8'h40;
      5'd8:  romByte = 8'hA1;
      5'd9:  romByte = 8'hA8;
      5'd10: romByte = 8'h3F;
      5'd11: romByte = 8'hD5;
      5'd12: romByte = 8'h80;
      5'd13: romByte = 8'hD9;
      5'd14: romByte = 8'h22;
      5'd15: romByte = 8'hDB;
      5'd16: romByte = 8'h20;
      5'd17: romByte = 8'h8D;
      5'd18: romByte = 8'h14;
      5'd19: romByte = 8'hAF;
      default: romByte = 8'h00;
    endcase
  end

`ifdef SCREEN_INVERT_EN
  assign dataByte = pixelData ^ 8'hFF;
`else
  assign dataByte = pixelData;
`endif

  // The SPI pins are decoded straight from state so that an asynchronous
  // reset releases the bus (ioCs high, ioSclk high) in the same instant.
  // phase 0 is the low half of a bit, phase 1 the high half.
  assign ioSclk  = !((state == SEND) && !phase);
  assign ioSdin  = (state == SEND) && shiftReg[7];
  assign ioCs    = (state != SEND);
  assign ioReset = (state != RESET_PULSE);

  // Main sequencer. The address only moves in CHECK_INIT, after the previous
  // data byte has fully left, so the upstream registered byte lines up with
  // FETCH_DATA two edges later.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= WAIT_HIGH;
      waitCount    <= '0;
      cmdIndex     <= '0;
      pixelAddress <= '0;
      shiftReg     <= '0;
      bitCount     <= '0;
      phase        <= 1'b0;
      ioDc         <= 1'b0;
    end else begin
      case (state)
        WAIT_HIGH, RESET_PULSE, WAIT_POST: begin
          if (waitCount == WAIT_LAST) begin
            waitCount <= '0;
            if (state == WAIT_HIGH)        state <= RESET_PULSE;
            else if (state == RESET_PULSE) state <= WAIT_POST;
            else                           state <= LOAD_CMD;
          end else begin
            waitCount <= waitCount + 32'd1;
          end
        end
        LOAD_CMD: begin
          shiftReg <= romByte;
          ioDc     <= 1'b0;
          bitCount <= 3'd7;
          phase    <= 1'b0;
          state    <= SEND;
        end
        SEND: begin
          if (!phase) begin
            phase <= 1'b1;
          end else if (bitCount == 3'd0) begin
            phase <= 1'b0;
            state <= CHECK_INIT;
          end else begin
            shiftReg <= {shiftReg[6:0], 1'b0};
            bitCount <= bitCount - 3'd1;
            phase    <= 1'b0;
          end
        end
        CHECK_INIT: begin
          if (ioDc) begin
            pixelAddress <= pixelAddress + 10'd1;
            state        <= LOAD_DATA;
          end else if (cmdIndex == LAST_CMD) begin
            state <= LOAD_DATA;
          end else begin
            cmdIndex <= cmdIndex + 5'd1;
            state    <= LOAD_CMD;
          end
        end
        LOAD_DATA: begin
          state <= FETCH_DATA;
        end
        FETCH_DATA: begin
          shiftReg <= dataByte;
          ioDc     <= 1'b1;
          bitCount <= 3'd7;
          phase    <= 1'b0;
          state    <= SEND;
        end
        default: state <= WAIT_HIGH;
      endcase
    end
  end

endmodule

// File: tb/tb_screen_driver.sv
// ---------------------------------------------------------------------------
// tb_screen_driver
//
// Drives screen_driver with a short power-up wait and a registered frame
// model (byte = address[7:0]). Expected SPI bytes are queued when a sequence
// is started and compared as the monitor reassembles bytes on ioSclk rises.
// ---------------------------------------------------------------------------
module tb_screen_driver;

  localparam logic [31:0] WAIT_CYCLES = 32'd4;

  logic       clk;
  logic       resetN;
  logic       ioSclk;
  logic       ioSdin;
  logic       ioCs;
  logic       ioDc;
  logic       ioReset;
  logic [9:0] pixelAddress;
  logic [7:0] pixelData;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
    logic [9:0] addr;
  } sbEntry_t;

  sbEntry_t sbQueue[$];

  logic [7:0] initRom [20] = '{8'hAE, 8'h81, 8'h7F, 8'hA6, 8'h20, 8'h00, 8'hC8,
                               8'h40, 8'hA1, 8'hA8, 8'h3F, 8'hD5, 8'h80, 8'hD9,
                               8'h22, 8'hDB, 8'h20, 8'h8D, 8'h14, 8'hAF};

  int checks = 0;
  int errors = 0;

  int monBits     = 0;
  int monPopped   = 0;
  int cycleCount  = 0;
  int lowCount    = 0;
  int lastStart   = 0;
  bit lastWasData = 1'b0;
  bit prevSclk    = 1'b1;
  bit prevCs      = 1'b1;
  logic [7:0] monShift = 8'h00;

  screen_driver #(.STARTUP_WAIT(WAIT_CYCLES)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .ioSclk       (ioSclk),
    .ioSdin       (ioSdin),
    .ioCs         (ioCs),
    .ioDc         (ioDc),
    .ioReset      (ioReset),
    .pixelAddress (pixelAddress),
    .pixelData    (pixelData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream text engine: one-cycle registered lookup of the frame byte.
  always @(posedge clk) pixelData <= pixelAddress[7:0];

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] expectedData(input logic [9:0] addr);
`ifdef SCREEN_INVERT_EN
    return addr[7:0] ^ 8'hFF;
`else
    return addr[7:0];
`endif
  endfunction

  // Queue a full init sequence followed by numData data bytes from address 0.
  task automatic applyStimulus(input int numData);
    sbEntry_t e;
    for (int i = 0; i < 20; i++) begin
      e.dc   = 1'b0;
      e.data = initRom[i];
      e.addr = 10'd0;
      sbQueue.push_back(e);
    end
    for (int i = 0; i < numData; i++) begin
      e.dc   = 1'b1;
      e.addr = 10'(i);
      e.data = expectedData(e.addr);
      sbQueue.push_back(e);
    end
  endtask

  // SPI monitor: samples on the falling clk edge, assembles a byte from the
  // eight ioSclk rises inside each chip-select window, and checks framing.
  always @(negedge clk) begin
    sbEntry_t exp;
    if (!resetN) begin
      monBits     = 0;
      prevSclk    = 1'b1;
      prevCs      = 1'b1;
      lowCount    = 0;
      lastWasData = 1'b0;
    end else begin
      cycleCount++;
      if (!ioCs) lowCount++;
      if (prevCs && !ioCs) begin
        if (lastWasData && ioDc)
          checkOutput("data_period", 32'(cycleCount - lastStart), 32'd19);
        lastStart = cycleCount;
      end
      if (!prevCs && ioCs) begin
        checkOutput("cs_low_width", 32'(lowCount), 32'd16);
        checkOutput("idle_lines", {30'd0, ioSclk, ioSdin}, 32'b10);
        lowCount = 0;
      end
      if (!ioCs && ioSclk && !prevSclk) begin
        monShift = {monShift[6:0], ioSdin};
        monBits++;
        if (monBits == 8) begin
          monBits = 0;
          if (sbQueue.size() == 0) begin
            checkOutput("sb_empty", 32'd1, 32'd0);
          end else begin
            exp = sbQueue.pop_front();
            checkOutput(exp.dc ? "data_byte" : "cmd_byte", {24'd0, monShift}, {24'd0, exp.data});
            checkOutput("dc", {31'd0, ioDc}, {31'd0, exp.dc});
            if (exp.dc) checkOutput("addr", {22'd0, pixelAddress}, {22'd0, exp.addr});
          end
          lastWasData = ioDc;
          monPopped++;
        end
      end
      prevSclk = ioSclk;
      prevCs   = ioCs;
    end
  end

  initial begin
    int  fallEdge;
    int  riseEdge;
    int  csEdge;
    int  target;
    bit  found;

    resetN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cs",   {31'd0, ioCs},    32'd1);
    checkOutput("rst_sclk", {31'd0, ioSclk},  32'd1);
    checkOutput("rst_sdin", {31'd0, ioSdin},  32'd0);
    checkOutput("rst_dc",   {31'd0, ioDc},    32'd0);
    checkOutput("rst_ioreset", {31'd0, ioReset}, 32'd1);
    checkOutput("rst_addr", {22'd0, pixelAddress}, 32'd0);

    // Power-up timing, counted in rising edges after release (first edge = 0).
    applyStimulus(10);
    @(negedge clk) resetN = 1'b1;
    fallEdge = -1;
    riseEdge = -1;
    csEdge   = -1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      if (!ioReset && fallEdge < 0) fallEdge = k;
      if (ioReset && fallEdge >= 0 && riseEdge < 0) riseEdge = k;
      if (!ioCs && csEdge < 0) csEdge = k;
    end
    checkOutput("ioreset_fall_edge", 32'(fallEdge), 32'd3);
    checkOutput("ioreset_rise_edge", 32'(riseEdge), 32'd7);
    checkOutput("first_cs_edge",     32'(csEdge),   32'd12);

    // Abort during bit 4 (low half) of the data byte at address 5.
    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(negedge clk);
      #2;
      if (monPopped == 25 && monBits == 3 && !ioSclk && !ioCs) found = 1'b1;
    end
    checkOutput("abort_point_found", {31'd0, found}, 32'd1);
    checkOutput("abort_addr", {22'd0, pixelAddress}, 32'd5);
    resetN = 1'b0;
    #1;
    checkOutput("abort_cs",   {31'd0, ioCs},   32'd1);
    checkOutput("abort_sclk", {31'd0, ioSclk}, 32'd1);
    checkOutput("abort_sdin", {31'd0, ioSdin}, 32'd0);
    checkOutput("abort_addr_rst", {22'd0, pixelAddress}, 32'd0);
    repeat (2) @(posedge clk);
    sbQueue.delete();

    // Full restart, then stream past the 1023 -> 0 wrap.
    applyStimulus(1035);
    target = monPopped + 20 + 1035;
    @(negedge clk) resetN = 1'b1;
    for (int i = 0; i < 25000 && monPopped < target; i++) @(negedge clk);
    checkOutput("stream_done", {31'd0, monPopped >= target}, 32'd1);
    checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
